mmu_controller: RTL and testbench

Parametrised virtual/physical memory controller with a direct-mapped, resettable, flushable TLB and a two-word page-table walker. It sits between the CPU memory port (`mc*`) and physical RAM (`ph*`). It supersedes the fixed 64-entry controller and adds configurable page size, TLB depth and RAM latency. New behaviour: TLB valid bits cleared on reset, TLB flush, write-protect and not-present faults, and fault codes.

---
 rtl/mmu_controller.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mmu_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_controller.sv
`default_nettype none
// ============================================================================
// Module      : mmu_controller
// Description : Virtual/physical memory controller. Direct-mapped TLB with
//               flush, two-word page-table walker, privilege / write-protect /
//               not-present fault reporting, and a configurable RAM latency.
//               Optional hit/miss counters are enabled by MMU_TLB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_controller #(
    parameter int VADDR_W      = 32,
    parameter int PADDR_W      = 32,
    parameter int PAGE_BITS    = 12,
    parameter int TLB_IDX_BITS = 6,
    parameter int MEM_LAT      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mcReadReq,
    input  logic               mcWriteReq,
    input  logic               mcAddrVirtual,
    input  logic               mcExecMode,
    input  logic [VADDR_W-1:0] mcRamAddress,
    input  logic [31:0]        mcRamIn,
    output logic [31:0]        mcRamOut,
    output logic [1:0]         mcStatus,
    output logic [1:0]         mcFaultCode,
    input  logic               tlbFlush,
    input  logic [PADDR_W-1:0] ptAddress,
`ifdef MMU_TLB_STATS_EN
    output logic [31:0]        tlbHits,
    output logic [31:0]        tlbMisses,
`endif
    output logic [PADDR_W-1:0] phRamAddress,
    output logic [31:0]        phRamOut,
    output logic               phReadReq,
    output logic               phWriteReq,
    input  logic [31:0]        phRamIn
);
    localparam int VPN_W = VADDR_W - PAGE_BITS;
    localparam int PPN_W = PADDR_W - PAGE_BITS;
    localparam int TLB_N = 1 << TLB_IDX_BITS;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        READY = 3'd0,
        PRAM  = 3'd1,
        PTW0  = 3'd2,
        PTW1  = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t state, state_next;

    // TLB storage: only the valid bits need a reset value
    logic [TLB_N-1:0] tlb_valid;
    logic [TLB_N-1:0] tlb_super;
    logic [TLB_N-1:0] tlb_ro;
    logic [VPN_W-1:0] tlb_tag [TLB_N];
    logic [PPN_W-1:0] tlb_ppn [TLB_N];

    // Request context captured at acceptance, used by the walker
    logic                    req_wr, req_user;
    logic [VPN_W-1:0]        req_vpn;
    logic [TLB_IDX_BITS-1:0] req_idx;
    logic [PAGE_BITS-1:0]    req_off;
    logic [31:0]             req_wdata;
    logic                    pte_present, pte_super, pte_ro;
    logic                    flush_pending;
    logic [1:0]              fault_code;
    logic [CNT_W-1:0]        cnt;

    // Fold the VPN into a TLB index: XOR of index-wide slices, LSB first
    function automatic logic [TLB_IDX_BITS-1:0] fold_vpn(input logic [VPN_W-1:0] v);
        logic [TLB_IDX_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < VPN_W; i++) r[i % TLB_IDX_BITS] ^= v[i];
        return r;
    endfunction

    logic [VPN_W-1:0]        in_vpn;
    logic [PAGE_BITS-1:0]    in_off;
    logic [TLB_IDX_BITS-1:0] in_idx;
    logic                    in_req, in_wr, hit;
    logic [PADDR_W-1:0]      pte_addr;
    logic [PPN_W-1:0]        walk_ppn;

    assign in_vpn   = mcRamAddress[VADDR_W-1:PAGE_BITS];
    assign in_off   = mcRamAddress[PAGE_BITS-1:0];
    assign in_idx   = fold_vpn(in_vpn);
    assign in_req   = mcReadReq | mcWriteReq;
    assign in_wr    = mcWriteReq & ~mcReadReq;
    assign hit      = tlb_valid[in_idx] && (tlb_tag[in_idx] == in_vpn);
    assign pte_addr = ptAddress + PADDR_W'({in_vpn, 3'b000});
    assign walk_ppn = phRamIn[PPN_W-1:0];

    logic               issue, issue_rd, flush_now, fill, capture, sample_w0;
    logic               latch_out, fault_set;
    logic [1:0]         fault_next;
    logic [PADDR_W-1:0] issue_addr;
    logic [31:0]        issue_data;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= READY;
        else        state <= state_next;
    end

    // Next-state and control decode
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_rd   = 1'b1;
        issue_addr = '0;
        issue_data = req_wdata;
        flush_now  = 1'b0;
        fill       = 1'b0;
        capture    = 1'b0;
        sample_w0  = 1'b0;
        latch_out  = 1'b0;
        fault_set  = 1'b0;
        fault_next = 2'd0;
        case (state)
            READY: begin
                if (tlbFlush || flush_pending) begin
                    flush_now = 1'b1;
                end else if (in_req) begin
                    capture    = 1'b1;
                    issue_data = mcRamIn;
                    if (!mcAddrVirtual) begin
                        issue = 1'b1; issue_rd = ~in_wr;
                        issue_addr = PADDR_W'(mcRamAddress);
                        state_next = PRAM;
                    end else if (hit) begin
                        if (tlb_super[in_idx] && mcExecMode) begin
                            fault_set = 1'b1; fault_next = 2'd2; state_next = FAULT;
                        end else if (tlb_ro[in_idx] && in_wr) begin
                            fault_set = 1'b1; fault_next = 2'd3; state_next = FAULT;
                        end else begin
                            issue = 1'b1; issue_rd = ~in_wr;
                            issue_addr = {tlb_ppn[in_idx], in_off};
                            state_next = PRAM;
                        end
                    end else begin
                        issue = 1'b1; issue_addr = pte_addr;
                        state_next = PTW0;
                    end
                end
            end
            PRAM: if (cnt == '0) begin
                latch_out  = ~req_wr;
                state_next = DONE;
            end
            PTW0: if (cnt == '0) begin
                sample_w0  = 1'b1;
                issue      = 1'b1;
                issue_addr = phRamAddress + PADDR_W'(4);
                state_next = PTW1;
            end
            PTW1: if (cnt == '0) begin
                if (!pte_present) begin
                    fault_set = 1'b1; fault_next = 2'd1; state_next = FAULT;
                end else begin
                    fill = 1'b1;
                    if (pte_super && req_user) begin
                        fault_set = 1'b1; fault_next = 2'd2; state_next = FAULT;
                    end else if (pte_ro && req_wr) begin
                        fault_set = 1'b1; fault_next = 2'd3; state_next = FAULT;
                    end else begin
                        issue = 1'b1; issue_rd = ~req_wr;
                        issue_addr = {walk_ppn, req_off};
                        state_next = PRAM;
                    end
                end
            end
            DONE:    state_next = READY;
            FAULT:   state_next = READY;
            default: state_next = READY;
        endcase
    end

    // Datapath, strobes, latency counter and flush bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tlb_valid     <= '0;
            flush_pending <= 1'b0;
            cnt           <= '0;
            phReadReq     <= 1'b0;
            phWriteReq    <= 1'b0;
            phRamAddress  <= '0;
            phRamOut      <= '0;
            mcRamOut      <= '0;
            fault_code    <= 2'd0;
            req_wr        <= 1'b0;
            req_user      <= 1'b0;
            req_vpn       <= '0;
            req_idx       <= '0;
            req_off       <= '0;
            req_wdata     <= '0;
            pte_present   <= 1'b0;
            pte_super     <= 1'b0;
            pte_ro        <= 1'b0;
        end else begin
            phReadReq  <= issue & issue_rd;
            phWriteReq <= issue & ~issue_rd;
            fault_code <= fault_set ? fault_next : 2'd0;
            if (issue) begin
                phRamAddress <= issue_addr;
                phRamOut     <= issue_data;
                cnt          <= LAT_LOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                req_wr    <= in_wr;
                req_user  <= mcExecMode;
                req_vpn   <= in_vpn;
                req_idx   <= in_idx;
                req_off   <= in_off;
                req_wdata <= mcRamIn;
            end
            if (sample_w0) begin
                pte_present <= phRamIn[31];
                pte_super   <= phRamIn[30];
                pte_ro      <= phRamIn[29];
            end
            if (latch_out) mcRamOut <= phRamIn;
            // A flush seen while busy is remembered and replayed in READY
            if (flush_now)                       flush_pending <= 1'b0;
            else if (tlbFlush && state != READY) flush_pending <= 1'b1;
            if (flush_now)  tlb_valid          <= '0;
            else if (fill)  tlb_valid[req_idx] <= 1'b1;
        end
    end

    // TLB payload, written on a successful walk
    always_ff @(posedge clk) begin
        if (fill) begin
            tlb_super[req_idx] <= pte_super;
            tlb_ro[req_idx]    <= pte_ro;
            tlb_tag[req_idx]   <= req_vpn;
            tlb_ppn[req_idx]   <= walk_ppn;
        end
    end

    // Status decode from state
    always_comb begin
        case (state)
            DONE:    mcStatus = 2'd2;
            FAULT:   mcStatus = 2'd0;
            default: mcStatus = 2'd1;
        endcase
    end
    assign mcFaultCode = fault_code;

`ifdef MMU_TLB_STATS_EN
    logic count_lookup;
    assign count_lookup = (state == READY) && !tlbFlush && !flush_pending &&
                          in_req && mcAddrVirtual;

    // Saturating hit/miss counters, unaffected by flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tlbHits   <= '0;
            tlbMisses <= '0;
        end else if (count_lookup) begin
            if (hit) begin
                if (tlbHits != 32'hFFFF_FFFF) tlbHits <= tlbHits + 32'd1;
            end else begin
                if (tlbMisses != 32'hFFFF_FFFF) tlbMisses <= tlbMisses + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_controller
// Description : Directed, table-driven bench for mmu_controller with a
//               behavioural physical RAM holding a small page table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mcReadReq = 1'b0, mcWriteReq = 1'b0;
    logic        mcAddrVirtual = 1'b0, mcExecMode = 1'b0;
    logic [31:0] mcRamAddress = '0, mcRamIn = '0;
    logic [31:0] mcRamOut;
    logic [1:0]  mcStatus, mcFaultCode;
    logic        tlbFlush = 1'b0;
    logic [31:0] ptAddress = 32'h0000_8000;
    logic [31:0] phRamAddress, phRamOut;
    logic        phReadReq, phWriteReq;
    logic [31:0] phRamIn = '0;
`ifdef MMU_TLB_STATS_EN
    logic [31:0] tlbHits, tlbMisses;
`endif

    mmu_controller dut (
        .clk(clk), .reset(reset),
        .mcReadReq(mcReadReq), .mcWriteReq(mcWriteReq),
        .mcAddrVirtual(mcAddrVirtual), .mcExecMode(mcExecMode),
        .mcRamAddress(mcRamAddress), .mcRamIn(mcRamIn),
        .mcRamOut(mcRamOut), .mcStatus(mcStatus), .mcFaultCode(mcFaultCode),
        .tlbFlush(tlbFlush), .ptAddress(ptAddress),
`ifdef MMU_TLB_STATS_EN
        .tlbHits(tlbHits), .tlbMisses(tlbMisses),
`endif
        .phRamAddress(phRamAddress), .phRamOut(phRamOut),
        .phReadReq(phReadReq), .phWriteReq(phWriteReq), .phRamIn(phRamIn)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural RAM ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pte5_w0 = 32'h4000_0000;
    int          str_total = 0;
    int          wr_total = 0;
    logic [31:0] last_addr = '0;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_8018: return 32'h8000_0000;  // vpn 3: present
            32'h0000_801C: return 32'h0000_0055;
            32'h0005_5ABC: return 32'h1234_5678;
            32'h0000_8028: return pte5_w0;        // vpn 5
            32'h0000_802C: return 32'h0000_0066;
            32'h0000_8030: return 32'hC000_0000;  // vpn 6: present+super
            32'h0000_8034: return 32'h0000_0077;
            32'h0000_8038: return 32'hA000_0000;  // vpn 7: present+ro
            32'h0000_803C: return 32'h0000_0088;
            default:       return 32'hA5A5_0000 ^ a;
        endcase
    endfunction

    // Observe strobes half a cycle after they appear and serve the RAM
    always @(negedge clk) begin
        if (phReadReq) begin
            str_total = str_total + 1;
            last_addr = phRamAddress;
        end
        if (phWriteReq) begin
            str_total = str_total + 1;
            wr_total  = wr_total + 1;
            last_addr = phRamAddress;
            mem[phRamAddress] = phRamOut;
        end
        phRamIn = rd_mem(phRamAddress);
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd, wr, virt, user, fix5;
        int          flush_at;   // -1 none, 0 with request, k: asserted after edge k
        logic [31:0] addr, wdata;
        logic [1:0]  st, code;
        int          lat, nstr;
        logic [31:0] rdata, phaddr;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic virt,
                                input logic user, input logic fix5, input int flush_at,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] st, input logic [1:0] code,
                                input int lat, input int nstr,
                                input logic [31:0] rdata, input logic [31:0] phaddr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.virt = virt; v.user = user; v.fix5 = fix5;
        v.flush_at = flush_at; v.addr = addr; v.wdata = wdata; v.st = st;
        v.code = code; v.lat = lat; v.nstr = nstr; v.rdata = rdata; v.phaddr = phaddr;
        return v;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int  cycles, edges, s0, w0;
        bit  done;
        if (v.fix5) pte5_w0 = 32'h8000_0000;
        @(negedge clk);
        s0 = str_total; w0 = wr_total;
        mcReadReq = v.rd; mcWriteReq = v.wr; mcAddrVirtual = v.virt;
        mcExecMode = v.user; mcRamAddress = v.addr; mcRamIn = v.wdata;
        tlbFlush = (v.flush_at == 0);
        cycles = 0; edges = 0; done = 0;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            tlbFlush = (edges == v.flush_at);
            if (mcStatus !== 2'd1) done = 1; else cycles++;
        end
        tlbFlush = 1'b0; mcReadReq = 1'b0; mcWriteReq = 1'b0;
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " status"}, 32'(mcStatus), 32'(v.st));
        check({tag, " fault code"}, 32'(mcFaultCode), 32'(v.code));
        check({tag, " latency"}, 32'(cycles), 32'(v.lat));
        @(negedge clk);
        check({tag, " strobes"}, 32'(str_total - s0), 32'(v.nstr));
        check({tag, " write strobe"}, 32'(wr_total - w0),
              32'((v.st == 2'd2 && v.wr && !v.rd) ? 1 : 0));
        if (v.st == 2'd2) check({tag, " read data"}, mcRamOut, v.rdata);
        if (v.nstr > 0)   check({tag, " last address"}, last_addr, v.phaddr);
        if (v.st == 2'd2 && v.wr && !v.rd) check({tag, " write data"}, phRamOut, v.wdata);
        @(posedge clk); #1;
        check({tag, " back to idle"}, 32'(mcStatus), 32'd1);
        check({tag, " code cleared"}, 32'(mcFaultCode), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    vec_t va[17];
    vec_t vb[4];

    initial begin
        //          rd wr vi us fx fl  addr          wdata         st   cd  lat n  rdata         phaddr
        va[0]  = mk(1, 0, 0, 0, 0, -1, 32'h100,      32'h0,        2'd2, 0, 2, 1, 32'hDEADBEEF, 32'h100);
        va[1]  = mk(1, 0, 1, 0, 0, -1, 32'h3ABC,     32'h0,        2'd2, 0, 6, 3, 32'h12345678, 32'h55ABC);
        va[2]  = mk(1, 0, 1, 0, 0, -1, 32'h3ABC,     32'h0,        2'd2, 0, 2, 1, 32'h12345678, 32'h55ABC);
        va[3]  = mk(1, 0, 1, 0, 0, -1, 32'h5123,     32'h0,        2'd0, 1, 4, 2, 32'h0,        32'h802C);
        va[4]  = mk(1, 0, 1, 1, 0, -1, 32'h6004,     32'h0,        2'd0, 2, 4, 2, 32'h0,        32'h8034);
        va[5]  = mk(1, 0, 1, 1, 0, -1, 32'h6004,     32'h0,        2'd0, 2, 0, 0, 32'h0,        32'h0);
        va[6]  = mk(1, 0, 1, 0, 0, -1, 32'h6004,     32'h0,        2'd2, 0, 2, 1, 32'hA5A27004, 32'h77004);
        va[7]  = mk(0, 1, 1, 0, 0, -1, 32'h7010,     32'hBEEF0001, 2'd0, 3, 4, 2, 32'h0,        32'h803C);
        va[8]  = mk(0, 1, 1, 0, 0, -1, 32'h7010,     32'hBEEF0001, 2'd0, 3, 0, 0, 32'h0,        32'h0);
        va[9]  = mk(1, 0, 1, 0, 0, -1, 32'h7010,     32'h0,        2'd2, 0, 2, 1, 32'hA5AD8010, 32'h88010);
        va[10] = mk(0, 1, 0, 0, 0, -1, 32'h200,      32'hCAFEF00D, 2'd2, 0, 2, 1, 32'hA5AD8010, 32'h200);
        va[11] = mk(0, 1, 1, 1, 0, -1, 32'h3ABC,     32'h11112222, 2'd2, 0, 2, 1, 32'hA5AD8010, 32'h55ABC);
        va[12] = mk(1, 0, 1, 0, 1, -1, 32'h5123,     32'h0,        2'd2, 0, 6, 3, 32'hA5A36123, 32'h66123);
        va[13] = mk(1, 1, 0, 0, 0, -1, 32'h100,      32'h99999999, 2'd2, 0, 2, 1, 32'hDEADBEEF, 32'h100);
        va[14] = mk(1, 0, 1, 0, 0,  2, 32'h40000,    32'h0,        2'd2, 0, 6, 3, 32'hFD854000, 32'h58204000);
        va[15] = mk(1, 0, 1, 0, 0, -1, 32'h3ABC,     32'h0,        2'd2, 0, 6, 3, 32'h11112222, 32'h55ABC);
        va[16] = mk(1, 0, 0, 0, 0,  0, 32'h100,      32'h0,        2'd2, 0, 3, 1, 32'hDEADBEEF, 32'h100);
        vb[0]  = mk(1, 0, 1, 0, 0, -1, 32'h3ABC,     32'h0,        2'd2, 0, 6, 3, 32'h11112222, 32'h55ABC);
        vb[1]  = mk(1, 0, 1, 0, 0, -1, 32'h3ABC,     32'h0,        2'd2, 0, 2, 1, 32'h11112222, 32'h55ABC);
        vb[2]  = mk(1, 0, 1, 0, 0, -1, 32'h5123,     32'h0,        2'd2, 0, 6, 3, 32'hA5A36123, 32'h66123);
        vb[3]  = mk(1, 0, 1, 0, 0, -1, 32'h6004,     32'h0,        2'd2, 0, 6, 3, 32'hA5A27004, 32'h77004);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset status", 32'(mcStatus), 32'd1);
        check("reset code", 32'(mcFaultCode), 32'd0);
        check("reset rd strobe", 32'(phReadReq), 32'd0);
        check("reset wr strobe", 32'(phWriteReq), 32'd0);
        check("reset ram out", mcRamOut, 32'd0);
        check("reset ph addr", phRamAddress, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 17; i++) run_vec($sformatf("a%0d", i), va[i]);

        // Reset while the walker waits for PTE word0
        @(negedge clk); tlbFlush = 1'b1;
        @(negedge clk); tlbFlush = 1'b0;
        @(negedge clk);
        mcReadReq = 1'b1; mcAddrVirtual = 1'b1; mcExecMode = 1'b0; mcRamAddress = 32'h3ABC;
        @(posedge clk); #1;
        check("ptw0 strobe", 32'(phReadReq), 32'd1);
        check("ptw0 address", phRamAddress, 32'h8018);
        reset = 1'b0;
        #1;
        check("abort status", 32'(mcStatus), 32'd1);
        check("abort rd strobe", 32'(phReadReq), 32'd0);
        check("abort ph addr", phRamAddress, 32'd0);
        check("abort ram out", mcRamOut, 32'd0);
        check("abort code", 32'(mcFaultCode), 32'd0);
        @(negedge clk);
        mcReadReq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 4; i++) run_vec($sformatf("b%0d", i), vb[i]);
`ifdef MMU_TLB_STATS_EN
        check("stats hits", tlbHits, 32'd1);
        check("stats misses", tlbMisses, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global safety net
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
